// File: rtl/cont_mem_ctrl_if.sv
// ----------------------------------------------------------------------------
// cont_mem_ctrl_if
//
// Input stream of encoded window hypervectors feeding the continuous memory
// controller. One transfer happens on each clock edge where in_valid and
// in_ready are both high.
//
// Signals:
//   in_valid  producer -> controller  HV on in_hv is valid
//   in_ready  controller -> producer  controller can accept an HV
//   in_hv     producer -> controller  encoded window HV (DIMENSIONS bits)
//   in_label  producer -> controller  ground truth (0 non-seizure, 1 seizure)
//   mode      producer -> controller  0 = train, 1 = infer
//
// Modports:
//   master  the encoder side (drives the HV)
//   slave   the controller side (drives in_ready)
// ----------------------------------------------------------------------------
interface cont_mem_ctrl_if #(
    parameter int DIMENSIONS = 10000
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DIMENSIONS-1:0] in_hv;
    logic                  in_label;
    logic                  mode;

    modport master (
        output in_valid,
        output in_hv,
        output in_label,
        output mode,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_hv,
        input  in_label,
        input  mode,
        output in_ready
    );
endinterface

// File: rtl/cont_mem_ctrl.sv
// ----------------------------------------------------------------------------
// cont_mem_ctrl
//
// Sequencer for the two-class continuous memory (non-seizure / seizure class
// hypervectors). Window HVs arrive over the in_if valid/ready stream.
//   train (mode=0): one-cycle bundling strobe to the class memory, then a
//                   one-cycle settle so the bundler output can propagate.
//   infer (mode=1): chunk-serial Hamming distance against both class HVs,
//                   CHUNK bits per cycle, then a one-cycle prediction strobe.
//
// Optional feature (macro CM_RETRAIN_EN): a mispredicted inference is
// followed by a bundling update of the HV into its true class.
//
// Ports:
//   clk, nrst      clock, synchronous active-low reset
//   in_if          slave side of the HV input stream
//   mem_en         update strobe to the class memory
//   mem_label      class to update (held while mem_en is low)
//   mem_hv         HV to bundle (held while mem_en is low)
//   ns_hv, s_hv    current non-seizure / seizure class HVs
//   pred_valid     one-cycle prediction strobe
//   pred_label     predicted class (tie -> non-seizure)
//   dist_ns/dist_s Hamming distances of the last completed inference
//   ns_count       number of non-seizure updates issued (saturating)
//   s_count        number of seizure updates issued (saturating)
//   busy           controller not idle
// ----------------------------------------------------------------------------
module cont_mem_ctrl #(
    parameter int DIMENSIONS = 10000,
    parameter int CHUNK      = 100,
    parameter int CNT_W      = 16,
    localparam int NUM_CHUNKS = (DIMENSIONS + CHUNK - 1) / CHUNK,
    localparam int DIST_W     = $clog2(DIMENSIONS + 1)
) (
    input  logic                  clk,
    input  logic                  nrst,
    cont_mem_ctrl_if.slave        in_if,
    output logic                  mem_en,
    output logic                  mem_label,
    output logic [DIMENSIONS-1:0] mem_hv,
    input  logic [DIMENSIONS-1:0] ns_hv,
    input  logic [DIMENSIONS-1:0] s_hv,
    output logic                  pred_valid,
    output logic                  pred_label,
    output logic [DIST_W-1:0]     dist_ns,
    output logic [DIST_W-1:0]     dist_s,
    output logic [CNT_W-1:0]      ns_count,
    output logic [CNT_W-1:0]      s_count,
    output logic                  busy
);

    localparam int PAD_W = NUM_CHUNKS * CHUNK;
    localparam int IDX_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {
        IDLE,
        UPDATE,
        SETTLE,
        COMPARE,
        DONE
    } state_e;

    state_e                state_q;
    state_e                state_d;

    logic [DIMENSIONS-1:0] hv_q;
`ifdef CM_RETRAIN_EN
    logic                  label_q;
`endif
    logic [IDX_W-1:0]      chunk_q;
    logic [DIST_W-1:0]     acc_ns_q;
    logic [DIST_W-1:0]     acc_s_q;
    logic [DIST_W-1:0]     dist_ns_q;
    logic [DIST_W-1:0]     dist_s_q;
    logic [CNT_W-1:0]      ns_count_q;
    logic [CNT_W-1:0]      s_count_q;
    logic                  mem_label_q;
    logic [DIMENSIONS-1:0] mem_hv_q;

    logic                  ready;
    logic                  transfer;
    logic                  last_chunk;
    logic                  pred;
    logic [PAD_W-1:0]      diff_ns_pad;
    logic [PAD_W-1:0]      diff_s_pad;
    logic [CHUNK-1:0]      slice_ns;
    logic [CHUNK-1:0]      slice_s;
    logic [DIST_W-1:0]     pop_ns;
    logic [DIST_W-1:0]     pop_s;
    logic [DIST_W-1:0]     sum_ns;
    logic [DIST_W-1:0]     sum_s;

    assign transfer   = in_if.in_valid & ready;
    assign last_chunk = (chunk_q == LAST_IDX);
    assign pred       = (dist_s_q < dist_ns_q);

    // Zero-extending the difference vectors to a whole number of chunks masks
    // the bits of a partial last chunk that lie above DIMENSIONS.
    assign diff_ns_pad = PAD_W'(hv_q ^ ns_hv);
    assign diff_s_pad  = PAD_W'(hv_q ^ s_hv);
    assign slice_ns    = diff_ns_pad[int'(chunk_q) * CHUNK +: CHUNK];
    assign slice_s     = diff_s_pad[int'(chunk_q) * CHUNK +: CHUNK];
    assign pop_ns      = DIST_W'($countones(slice_ns));
    assign pop_s       = DIST_W'($countones(slice_s));
    assign sum_ns      = acc_ns_q + pop_ns;
    assign sum_s       = acc_s_q + pop_s;

    // State register.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (transfer) begin
                    state_d = in_if.mode ? COMPARE : UPDATE;
                end
            end
            UPDATE:  state_d = SETTLE;
            SETTLE:  state_d = IDLE;
            COMPARE: begin
                if (last_chunk) begin
                    state_d = DONE;
                end
            end
            DONE: begin
`ifdef CM_RETRAIN_EN
                state_d = (pred != label_q) ? UPDATE : IDLE;
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the current state. in_ready is held low while
    // reset is asserted so nothing is offered before the controller is live.
    always_comb begin
        ready      = (state_q == IDLE) && nrst;
        mem_en     = (state_q == UPDATE);
        pred_valid = (state_q == DONE);
        busy       = (state_q != IDLE);
    end

    // Datapath: captured HV, chunk accumulators, result and counter registers.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            hv_q        <= '0;
`ifdef CM_RETRAIN_EN
            label_q     <= 1'b0;
`endif
            chunk_q     <= '0;
            acc_ns_q    <= '0;
            acc_s_q     <= '0;
            dist_ns_q   <= '0;
            dist_s_q    <= '0;
            ns_count_q  <= '0;
            s_count_q   <= '0;
            mem_label_q <= 1'b0;
            mem_hv_q    <= '0;
        end else begin
            if (transfer) begin
                hv_q <= in_if.in_hv;
`ifdef CM_RETRAIN_EN
                label_q <= in_if.in_label;
`endif
                if (in_if.mode) begin
                    chunk_q  <= '0;
                    acc_ns_q <= '0;
                    acc_s_q  <= '0;
                end else begin
                    // mem_hv/mem_label get their own registers so that a later
                    // inference capture does not disturb the held update values.
                    mem_hv_q    <= in_if.in_hv;
                    mem_label_q <= in_if.in_label;
                end
            end

`ifdef CM_RETRAIN_EN
            // A misprediction bundles the HV into its true class.
            if ((state_q == DONE) && (state_d == UPDATE)) begin
                mem_hv_q    <= hv_q;
                mem_label_q <= label_q;
            end
`endif

            if (state_q == COMPARE) begin
                acc_ns_q <= sum_ns;
                acc_s_q  <= sum_s;
                chunk_q  <= chunk_q + 1'b1;
                if (last_chunk) begin
                    dist_ns_q <= sum_ns;
                    dist_s_q  <= sum_s;
                end
            end

            if (state_q == UPDATE) begin
                if (mem_label_q) begin
                    if (s_count_q != CNT_MAX) begin
                        s_count_q <= s_count_q + 1'b1;
                    end
                end else begin
                    if (ns_count_q != CNT_MAX) begin
                        ns_count_q <= ns_count_q + 1'b1;
                    end
                end
            end
        end
    end

    assign in_if.in_ready = ready;
    assign mem_label      = mem_label_q;
    assign mem_hv         = mem_hv_q;
    assign pred_label     = pred;
    assign dist_ns        = dist_ns_q;
    assign dist_s         = dist_s_q;
    assign ns_count       = ns_count_q;
    assign s_count        = s_count_q;

endmodule

// File: tb/tb_cont_mem_ctrl.sv
// ----------------------------------------------------------------------------
// tb_cont_mem_ctrl
//
// Two controller instances: A with the full 10000-bit HV / 100-bit chunks,
// B with 250-bit HVs so the last chunk is partial. Expected values come from
// hand-derived tables and a reference model that works on whole vectors
// (popcount of the XOR) and on cycle offsets relative to the transfer.
// ----------------------------------------------------------------------------
module tb_cont_mem_ctrl;

    localparam int DA     = 10000;
    localparam int DB     = 250;
    localparam int CH     = 100;
    localparam int CW     = 16;
    localparam int NCA    = (DA + CH - 1) / CH;
    localparam int NCB    = (DB + CH - 1) / CH;
    localparam int DWA    = $clog2(DA + 1);
    localparam int DWB    = $clog2(DB + 1);
    localparam int MAXW   = 50;
    localparam int MAXREL = 300;
    localparam int NBP    = 8;
`ifdef CM_RETRAIN_EN
    localparam bit RETRAIN = 1'b1;
`else
    localparam bit RETRAIN = 1'b0;
`endif

    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    cont_mem_ctrl_if #(.DIMENSIONS(DA)) ifA ();
    cont_mem_ctrl_if #(.DIMENSIONS(DB)) ifB ();

    logic [DA-1:0]  nsA, sA, memHvA;
    logic [DB-1:0]  nsB, sB, memHvB;
    logic           memEnA, memLabelA, predValidA, predLabelA, busyA;
    logic           memEnB, memLabelB, predValidB, predLabelB, busyB;
    logic [DWA-1:0] distNsA, distSA;
    logic [DWB-1:0] distNsB, distSB;
    logic [CW-1:0]  nsCountA, sCountA, nsCountB, sCountB;

    cont_mem_ctrl #(.DIMENSIONS(DA), .CHUNK(CH), .CNT_W(CW)) dutA (
        .clk(clk), .nrst(nrst), .in_if(ifA),
        .mem_en(memEnA), .mem_label(memLabelA), .mem_hv(memHvA),
        .ns_hv(nsA), .s_hv(sA),
        .pred_valid(predValidA), .pred_label(predLabelA),
        .dist_ns(distNsA), .dist_s(distSA),
        .ns_count(nsCountA), .s_count(sCountA), .busy(busyA)
    );

    cont_mem_ctrl #(.DIMENSIONS(DB), .CHUNK(CH), .CNT_W(CW)) dutB (
        .clk(clk), .nrst(nrst), .in_if(ifB),
        .mem_en(memEnB), .mem_label(memLabelB), .mem_hv(memHvB),
        .ns_hv(nsB), .s_hv(sB),
        .pred_valid(predValidB), .pred_label(predLabelB),
        .dist_ns(distNsB), .dist_s(distSB),
        .ns_count(nsCountB), .s_count(sCountB), .busy(busyB)
    );

    // Observation view of whichever instance is selected.
    bit            sel;
    logic          obsReady, obsMemEn, obsMemLabel, obsPredValid, obsPredLabel, obsBusy;
    logic [DA-1:0] obsMemHv;
    int            obsDistNs, obsDistS, obsNsCount, obsSCount;

    always_comb begin
        obsReady     = sel ? ifB.in_ready : ifA.in_ready;
        obsMemEn     = sel ? memEnB : memEnA;
        obsMemLabel  = sel ? memLabelB : memLabelA;
        obsMemHv     = sel ? DA'(memHvB) : memHvA;
        obsPredValid = sel ? predValidB : predValidA;
        obsPredLabel = sel ? predLabelB : predLabelA;
        obsBusy      = sel ? busyB : busyA;
        obsDistNs    = sel ? int'(distNsB) : int'(distNsA);
        obsDistS     = sel ? int'(distSB) : int'(distSA);
        obsNsCount   = sel ? int'(nsCountB) : int'(nsCountA);
        obsSCount    = sel ? int'(sCountB) : int'(sCountA);
    end

    int nChecks = 0;
    int nFail   = 0;

    int            resMemEnCount, resMemEnRel, resPredCount, resPredRel, resReadyRel;
    int            resDistNs, resDistS;
    logic          resMemLabel, resPredLabel;
    logic [DA-1:0] resMemHv;
    logic [DA-1:0] maskB;
    int            mNs[2];
    int            mS[2];

    typedef struct {
        logic [DB-1:0] hv;
        logic [DB-1:0] ns;
        logic [DB-1:0] s;
        logic          label;
        int            expNs;
        int            expS;
        logic          expPred;
    } vec_t;

    vec_t tbl[6];

    task automatic checkOutput(input string name, input longint act, input longint exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [DA-1:0] randVec();
        logic [DA+15:0] t;
        for (int i = 0; i < (DA + 16) / 32; i++) t[i*32 +: 32] = $urandom;
        return t[DA-1:0];
    endfunction

    function automatic logic [DB-1:0] rng(input int lo, input int hi);
        logic [DB-1:0] r;
        r = '0;
        for (int i = lo; i <= hi; i++) r[i] = 1'b1;
        return r;
    endfunction

    function automatic int modelDist(input bit useB, input logic [DA-1:0] a, input logic [DA-1:0] b);
        return useB ? $countones((a ^ b) & maskB) : $countones(a ^ b);
    endfunction

    task automatic updateModel(input bit useB, input logic m, input logic l, input logic pred);
        if (!m || (RETRAIN && (pred != l))) begin
            if (l) mS[useB] = (mS[useB] < 65535) ? mS[useB] + 1 : mS[useB];
            else   mNs[useB] = (mNs[useB] < 65535) ? mNs[useB] + 1 : mNs[useB];
        end
    endtask

    task automatic checkCounts(input bit useB, input string name);
        sel = useB;
        #1;
        checkOutput({name, " ns_count"}, obsNsCount, mNs[useB]);
        checkOutput({name, " s_count"}, obsSCount, mS[useB]);
    endtask

    task automatic dropValid();
        ifA.in_valid = 1'b0;
        ifB.in_valid = 1'b0;
    endtask

    task automatic driveInput(input bit useB, input logic m, input logic l, input logic [DA-1:0] hv);
        if (useB) begin
            ifB.in_hv = hv[DB-1:0]; ifB.mode = m; ifB.in_label = l; ifB.in_valid = 1'b1;
        end else begin
            ifA.in_hv = hv; ifA.mode = m; ifA.in_label = l; ifA.in_valid = 1'b1;
        end
    endtask

    // One complete transaction; results are recorded as offsets from the
    // transfer edge (offset 1 is the cycle right after the transfer).
    task automatic applyStimulus(input bit useB, input logic m, input logic l,
                                 input logic [DA-1:0] hv, input logic [DA-1:0] ns,
                                 input logic [DA-1:0] s);
        int waited;
        sel = useB;
        resMemEnCount = 0; resMemEnRel = 0; resPredCount = 0; resPredRel = 0;
        resReadyRel = 0; resDistNs = -1; resDistS = -1;
        resMemLabel = 1'b0; resPredLabel = 1'b0; resMemHv = '0;
        @(negedge clk);
        if (useB) begin nsB = ns[DB-1:0]; sB = s[DB-1:0]; end
        else begin nsA = ns; sA = s; end
        driveInput(useB, m, l, hv);
        waited = 0;
        while (!obsReady && waited < MAXW) begin
            @(negedge clk);
            waited++;
        end
        if (!obsReady) begin
            checkOutput("accept timeout", 0, 1);
            dropValid();
            return;
        end
        @(posedge clk);
        @(negedge clk);
        dropValid();
        for (int rel = 1; rel <= MAXREL; rel++) begin
            if (rel > 1) @(negedge clk);
            if (obsMemEn) begin
                resMemEnCount++; resMemEnRel = rel;
                resMemLabel = obsMemLabel; resMemHv = obsMemHv;
            end
            if (obsPredValid) begin
                resPredCount++; resPredRel = rel; resPredLabel = obsPredLabel;
                resDistNs = obsDistNs; resDistS = obsDistS;
            end
            if (obsReady) begin
                resReadyRel = rel;
                break;
            end
        end
    endtask

    task automatic verifyTxn(input string name, input bit useB, input logic m, input logic l,
                             input logic [DA-1:0] hv, input logic [DA-1:0] ns,
                             input logic [DA-1:0] s);
        int   dns, ds, nc;
        logic pred, expMem;
        dns    = modelDist(useB, hv, ns);
        ds     = modelDist(useB, hv, s);
        pred   = (ds < dns);
        nc     = useB ? NCB : NCA;
        expMem = !m || (RETRAIN && (pred != l));
        checkOutput({name, " ready_rel"}, resReadyRel, !m ? 3 : (expMem ? nc + 4 : nc + 2));
        checkOutput({name, " mem_en_count"}, resMemEnCount, expMem ? 1 : 0);
        checkOutput({name, " mem_en_rel"}, resMemEnRel, !expMem ? 0 : (!m ? 1 : nc + 2));
        if (expMem) begin
            checkOutput({name, " mem_label"}, resMemLabel, l);
            checkOutput({name, " mem_hv"}, resMemHv === (useB ? (hv & maskB) : hv), 1);
        end
        checkOutput({name, " pred_count"}, resPredCount, m ? 1 : 0);
        if (m) begin
            checkOutput({name, " pred_rel"}, resPredRel, nc + 1);
            checkOutput({name, " dist_ns"}, resDistNs, dns);
            checkOutput({name, " dist_s"}, resDistS, ds);
            checkOutput({name, " pred_label"}, resPredLabel, pred);
        end
        updateModel(useB, m, l, pred);
        checkCounts(useB, name);
    endtask

    // Continuous in_valid on B with alternating modes.
    task automatic runBackpressure();
        logic [DA-1:0] ns, s, hv, curHv;
        logic          m, l, curL, pred;
        int            transfers, errs, memEv, predEv, expMemEv, expPredEv, viol;
        bit            just;
        transfers = 0; errs = 0; memEv = 0; predEv = 0;
        expMemEv = 0; expPredEv = 0; viol = 0; just = 0;
        curHv = '0; curL = 1'b0;
        sel = 1'b1;
        ns = randVec(); s = randVec();
        m = 1'b0; l = 1'(($urandom_range(0, 1))); hv = randVec();
        @(negedge clk);
        nsB = ns[DB-1:0]; sB = s[DB-1:0];
        driveInput(1'b1, m, l, hv);
        for (int c = 0; c < 600; c++) begin
            if (c > 0) @(negedge clk);
            if (just) begin
                just = 1'b0;
                if (!busyB || ifB.in_ready) viol++;
                m = ~m; l = 1'(($urandom_range(0, 1))); hv = randVec();
                driveInput(1'b1, m, l, hv);
            end
            if (busyB && ifB.in_ready) viol++;
            if (memEnB) begin
                memEv++;
                if ((memHvB !== curHv[DB-1:0]) || (memLabelB !== curL)) errs++;
            end
            if (predValidB) begin
                predEv++;
                if ((int'(distNsB) != modelDist(1'b1, curHv, ns)) ||
                    (int'(distSB) != modelDist(1'b1, curHv, s))) errs++;
            end
            if (ifB.in_ready) begin
                if (transfers == NBP) break;
                curHv = hv; curL = l;
                transfers++;
                just = 1'b1;
                pred = (modelDist(1'b1, hv, s) < modelDist(1'b1, hv, ns));
                if (!m) expMemEv++;
                else begin
                    expPredEv++;
                    if (RETRAIN && (pred != l)) expMemEv++;
                end
                updateModel(1'b1, m, l, pred);
            end
        end
        dropValid();
        checkOutput("bp transfers", transfers, NBP);
        checkOutput("bp mem_en events", memEv, expMemEv);
        checkOutput("bp pred events", predEv, expPredEv);
        checkOutput("bp content errors", errs, 0);
        checkOutput("bp handshake violations", viol, 0);
        checkCounts(1'b1, "bp");
    endtask

    // Reset held for two cycles while A is comparing chunk 40.
    task automatic runMidReset();
        int waited, events;
        sel = 1'b0;
        @(negedge clk);
        nsA = '0; sA = '1;
        driveInput(1'b0, 1'b1, 1'b0, randVec());
        waited = 0;
        while (!ifA.in_ready && waited < MAXW) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("rst accept", ifA.in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        dropValid();
        repeat (40) @(negedge clk);
        nrst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst in_ready during reset", ifA.in_ready, 0);
        checkOutput("rst busy during reset", busyA, 0);
        @(posedge clk);
        @(negedge clk);
        nrst = 1'b1;
        #1;
        checkOutput("rst busy", busyA, 0);
        checkOutput("rst in_ready", ifA.in_ready, 1);
        checkOutput("rst dist_ns", distNsA, 0);
        checkOutput("rst dist_s", distSA, 0);
        checkOutput("rst ns_count", nsCountA, 0);
        checkOutput("rst s_count", sCountA, 0);
        mNs[0] = 0; mS[0] = 0; mNs[1] = 0; mS[1] = 0;
        events = 0;
        repeat (NCA + 20) begin
            @(negedge clk);
            if (predValidA || memEnA) events++;
        end
        checkOutput("rst no strobes afterwards", events, 0);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [DA-1:0] hv, ns, s;
        logic          m, l;
        int            expMem;

        maskB = '0;
        maskB[DB-1:0] = '1;
        mNs[0] = 0; mS[0] = 0; mNs[1] = 0; mS[1] = 0;

        tbl[0] = '{hv: '0, ns: '0, s: '1, label: 1'b1, expNs: 0, expS: 250, expPred: 1'b0};
        tbl[1] = '{hv: '1, ns: '0, s: '1, label: 1'b1, expNs: 250, expS: 0, expPred: 1'b1};
        tbl[2] = '{hv: '0, ns: rng(125, 249), s: rng(0, 74) | rng(200, 249),
                   label: 1'b0, expNs: 125, expS: 125, expPred: 1'b0};
        tbl[3] = '{hv: rng(0, 0), ns: '0, s: '0, label: 1'b0, expNs: 1, expS: 1, expPred: 1'b0};
        tbl[4] = '{hv: '0, ns: rng(200, 249), s: rng(0, 99),
                   label: 1'b0, expNs: 50, expS: 100, expPred: 1'b0};
        tbl[5] = '{hv: rng(200, 249), ns: '0, s: rng(200, 249),
                   label: 1'b0, expNs: 50, expS: 0, expPred: 1'b1};

        sel = 1'b0;
        nrst = 1'b0;
        dropValid();
        ifA.in_hv = '0; ifA.mode = 1'b0; ifA.in_label = 1'b0;
        ifB.in_hv = '0; ifB.mode = 1'b0; ifB.in_label = 1'b0;
        nsA = '0; sA = '0; nsB = '0; sB = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset in_ready low", ifA.in_ready, 0);
        nrst = 1'b1;
        #1;
        checkOutput("reset A in_ready", ifA.in_ready, 1);
        checkOutput("reset A busy", busyA, 0);
        checkOutput("reset A mem_en", memEnA, 0);
        checkOutput("reset A pred_valid", predValidA, 0);
        checkOutput("reset A dist_ns", distNsA, 0);
        checkOutput("reset A s_count", sCountA, 0);
        checkOutput("reset B in_ready", ifB.in_ready, 1);
        checkOutput("reset B ns_count", nsCountB, 0);

        // Train A: all-ones HV into the seizure class.
        applyStimulus(1'b0, 1'b0, 1'b1, '1, '0, '0);
        checkOutput("train mem_en_count", resMemEnCount, 1);
        checkOutput("train mem_en_rel", resMemEnRel, 1);
        checkOutput("train mem_label", resMemLabel, 1);
        checkOutput("train mem_hv ones", resMemHv === {DA{1'b1}}, 1);
        checkOutput("train ready_rel", resReadyRel, 3);
        checkOutput("train pred_count", resPredCount, 0);
        updateModel(1'b0, 1'b0, 1'b1, 1'b0);
        checkCounts(1'b0, "train");

        // Infer A: low 3000 bits set, ns=0, s=all-ones.
        hv = '0;
        for (int i = 0; i < 3000; i++) hv[i] = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b0, hv, '0, '1);
        checkOutput("infer pred_rel", resPredRel, NCA + 1);
        checkOutput("infer pred_count", resPredCount, 1);
        checkOutput("infer dist_ns", resDistNs, 3000);
        checkOutput("infer dist_s", resDistS, 7000);
        checkOutput("infer pred_label", resPredLabel, 0);
        checkOutput("infer ready_rel", resReadyRel, NCA + 2);
        checkOutput("infer mem_en_count", resMemEnCount, 0);
        updateModel(1'b0, 1'b1, 1'b0, 1'b0);
        checkCounts(1'b0, "infer");

        // Table of inference vectors on B (partial last chunk, tie, retrain).
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b1, tbl[i].label, DA'(tbl[i].hv), DA'(tbl[i].ns), DA'(tbl[i].s));
            expMem = (RETRAIN && (tbl[i].expPred != tbl[i].label)) ? 1 : 0;
            checkOutput($sformatf("tbl%0d pred_rel", i), resPredRel, NCB + 1);
            checkOutput($sformatf("tbl%0d dist_ns", i), resDistNs, tbl[i].expNs);
            checkOutput($sformatf("tbl%0d dist_s", i), resDistS, tbl[i].expS);
            checkOutput($sformatf("tbl%0d pred_label", i), resPredLabel, tbl[i].expPred);
            checkOutput($sformatf("tbl%0d mem_en_count", i), resMemEnCount, expMem);
            checkOutput($sformatf("tbl%0d mem_en_rel", i), resMemEnRel, expMem * (NCB + 2));
            checkOutput($sformatf("tbl%0d ready_rel", i), resReadyRel, expMem ? NCB + 4 : NCB + 2);
            updateModel(1'b1, 1'b1, tbl[i].label, tbl[i].expPred);
            checkCounts(1'b1, $sformatf("tbl%0d", i));
        end

        // Randomised transactions against the model.
        for (int i = 0; i < 14; i++) begin
            bit useB;
            useB = (i >= 2);
            m  = 1'(($urandom_range(0, 1)));
            l  = 1'(($urandom_range(0, 1)));
            hv = randVec(); ns = randVec(); s = randVec();
            applyStimulus(useB, m, l, hv, ns, s);
            verifyTxn($sformatf("rand%0d", i), useB, m, l, hv, ns, s);
        end

        runBackpressure();
        runMidReset();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
